// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state type and round-robin helper for the SDRAM read arbiter
package sdram_arb_pkg;
  localparam int MAX_NPORTS = 8;
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} arb_state_e;
  // one-hot pick of the first requester after last, scanning n ports cyclically
  function automatic logic [MAX_NPORTS-1:0] rr_next(input logic [MAX_NPORTS-1:0] req,
                                                    input logic [2:0] last,
                                                    input logic [3:0] n);
    logic [MAX_NPORTS-1:0] pick;
    logic [3:0] idx;
    pick = '0;
    for (int k = MAX_NPORTS; k >= 1; k--) begin
      idx = {1'b0, last} + 4'(k);
      idx = idx >= n ? idx - n : idx;
      if (4'(k) <= n && req[idx[2:0]]) pick = MAX_NPORTS'(1) << idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/sdram_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder over NPORTS requesters
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  localparam int LW = NPORTS > 1 ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [LW-1:0]     last,
  output logic [NPORTS-1:0] pick
);
  logic [MAX_NPORTS-1:0] req_w, pick_w;
  logic unused_pick;
  always_comb begin
    req_w = '0;
    req_w[NPORTS-1:0] = req;
    pick_w = rr_next(req_w, 3'(last), 4'(NPORTS));
    pick = pick_w[NPORTS-1:0];
    unused_pick = ^pick_w;
  end
endmodule

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: round-robin share of one SDRAM read master, grant held per element fetch
module sdram_rd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS  = 3,
  parameter int MAX_OUT = 18,
  parameter int HOLD    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    rq_read,
  input  logic [32*NPORTS-1:0] rq_address,
  input  logic [2*NPORTS-1:0]  rq_byteenable,
  output logic [NPORTS-1:0]    rq_waitrequest,
  output logic [15:0]          rq_readdata,
  output logic [NPORTS-1:0]    rq_readdatavalid,
  output logic                 avm_m0_read,
  output logic [31:0]          avm_m0_address,
  output logic [1:0]           avm_m0_byteenable,
  input  logic [15:0]          avm_m0_readdata,
  input  logic                 avm_m0_readdatavalid,
  input  logic                 avm_m0_waitrequest,
  output logic [NPORTS-1:0]    grant,
  output logic                 err_orphan
);
  localparam int LW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;

  if (NPORTS < 2 || NPORTS > MAX_NPORTS) begin : g_bad_nports
    $error("NPORTS must be in 2..8");
  end

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d, pick;
  logic [LW-1:0]     owner_q, owner_d, last_q, last_d, pick_idx;
  logic [OW-1:0]     out_q, out_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              orphan_q, orphan_d;
  logic              own_rd, active, full, accept, ret;

  rr_pick #(.NPORTS(NPORTS)) u_pick (.req(rq_read), .last(last_q), .pick(pick));

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NPORTS; i++) if (pick[i]) pick_idx = LW'(i);
  end

  // owner path is forwarded combinationally in OWN, and in DRAIN the cycle the owner resumes
  always_comb begin
    own_rd = rq_read[owner_q];
    active = state_q == OWN || (state_q == DRAIN && own_rd);
    full = out_q == OW'(MAX_OUT);
    avm_m0_read = active && own_rd && !full;
    avm_m0_address = active ? rq_address[{owner_q, 5'd0} +: 32] : '0;
    avm_m0_byteenable = active ? rq_byteenable[{owner_q, 1'b0} +: 2] : '0;
    rq_waitrequest = '1;
    if (active) rq_waitrequest[owner_q] = full || avm_m0_waitrequest;
    accept = avm_m0_read && !avm_m0_waitrequest;
    ret = avm_m0_readdatavalid && out_q != '0;
    rq_readdata = avm_m0_readdata;
    rq_readdatavalid = ret ? grant_q : '0;
    out_d = out_q + OW'(accept) - OW'(ret);
    orphan_d = orphan_q || (avm_m0_readdatavalid && out_q == '0);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d = last_q;
    hold_d = hold_q;
    case (state_q)
      IDLE:
        if (|rq_read) begin
          state_d = OWN;
          grant_d = pick;
          owner_d = pick_idx;
        end
      OWN:
        if (!own_rd) begin
          state_d = DRAIN;
          hold_d = '0;
        end
      DRAIN:
        if (own_rd) state_d = OWN;
        else if (out_q != '0) hold_d = '0;
        else if (hold_q == HW'(HOLD - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          last_d = owner_q;
          hold_d = '0;
        end
        else hold_d = hold_q + HW'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q <= LW'(NPORTS - 1);
      out_q <= '0;
      hold_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q <= last_d;
      out_q <= out_d;
      hold_q <= hold_d;
      orphan_q <= orphan_d;
    end
  end

  assign grant = grant_q;
  assign err_orphan = orphan_q;
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// tb_sdram_rd_arbiter: scoreboard bench with an in-order SDRAM controller model
module tb_sdram_rd_arbiter;
  localparam int NP = 3, MAXO = 18, HLD = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [NP-1:0] rq_read = '0;
  logic [32*NP-1:0] rq_address = '0;
  logic [2*NP-1:0] rq_byteenable = '0;
  logic [NP-1:0] rq_waitrequest, rq_readdatavalid, grant;
  logic [15:0] rq_readdata;
  logic [15:0] avm_m0_readdata = '0;
  logic avm_m0_readdatavalid = 1'b0, avm_m0_waitrequest = 1'b0;
  logic avm_m0_read, err_orphan;
  logic [31:0] avm_m0_address;
  logic [1:0] avm_m0_byteenable;

  typedef struct {int p; logic [15:0] d;} sb_t;
  typedef struct {int due; logic [15:0] d;} mem_t;
  sb_t sb[$];
  mem_t mem_q[$];
  logic [NP-1:0] glog[$];
  logic [NP-1:0] prev_g = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, bad_wait = 0, bad_mix = 0, stray = 0;
  int ret_cnt[NP];
  bit mem_stall = 1'b0, mem_rand = 1'b0;

  sdram_rd_arbiter #(.NPORTS(NP), .MAX_OUT(MAXO), .HOLD(HLD)) dut (
    .clk(clk), .reset(reset),
    .rq_read(rq_read), .rq_address(rq_address), .rq_byteenable(rq_byteenable),
    .rq_waitrequest(rq_waitrequest), .rq_readdata(rq_readdata),
    .rq_readdatavalid(rq_readdatavalid),
    .avm_m0_read(avm_m0_read), .avm_m0_address(avm_m0_address),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest),
    .grant(grant), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_data(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // controller model: in-order returns three cycles after acceptance
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    avm_m0_waitrequest = mem_rand && $urandom_range(0, 2) == 0;
    if (!mem_stall && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      avm_m0_readdatavalid = 1'b1;
      avm_m0_readdata = mem_q[0].d;
      void'(mem_q.pop_front());
    end else begin
      avm_m0_readdatavalid = 1'b0;
      avm_m0_readdata = 16'h0;
    end
  end

  always @(negedge clk) begin : mon
    sb_t e;
    if (!reset) begin
      if (avm_m0_read && !avm_m0_waitrequest) begin
        if (sb.size() > 0 && int'(avm_m0_address[15:12]) - 1 != sb[0].p) bad_mix++;
        mem_q.push_back('{cyc + 3, exp_data(avm_m0_address)});
      end
      for (int p = 0; p < NP; p++) begin
        if (rq_read[p] && !rq_waitrequest[p]) sb.push_back('{p, exp_data(rq_address[32*p +: 32])});
        if (!grant[p] && !rq_waitrequest[p]) bad_wait++;
      end
      if (|rq_readdatavalid) begin
        if (sb.size() == 0) stray++;
        else begin
          e = sb.pop_front();
          check("ret_port", 32'(rq_readdatavalid), 32'(1 << e.p));
          check("ret_data", 32'(rq_readdata), 32'(e.d));
          ret_cnt[e.p]++;
        end
      end
      if (grant != prev_g) begin
        if (grant != '0) glog.push_back(grant);
        prev_g = grant;
      end
    end
  end

  task automatic do_reset(input bit flush);
    reset = 1'b1;
    rq_read = '0;
    if (flush) mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    glog.delete();
    foreach (ret_cnt[i]) ret_cnt[i] = 0;
  endtask

  // reader model: one element of n halfwords, optional one-cycle gap after `gap` accepts
  task automatic fetch(input int p, input int n, input int gap);
    int k = 0, t = 0;
    bit gapped = 1'b0;
    rq_byteenable[2*p +: 2] = 2'b11;
    while (k < n) begin
      rq_read[p] = 1'b1;
      rq_address[32*p +: 32] = 32'h1000 * (p + 1) + 32'(2 * k);
      @(negedge clk);
      if (!rq_waitrequest[p]) k++;
      @(posedge clk);
      #1;
      if (gap > 0 && k == gap && !gapped) begin
        gapped = 1'b1;
        rq_read[p] = 1'b0;
        @(posedge clk);
        #1;
      end
      t++;
      if (t > 3000) begin
        check("fetch_timeout", 32'(k), 32'(n));
        break;
      end
    end
    rq_read[p] = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || mem_q.size() != 0) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 32'(sb.size()), 0);
    repeat (HLD + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset(1'b1);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_wait", 32'(rq_waitrequest), 32'({NP{1'b1}}));
    check("rst_rdv", 32'(rq_readdatavalid), 0);
    check("rst_avm_read", 32'(avm_m0_read), 0);
    check("rst_orphan", 32'(err_orphan), 0);
    @(posedge clk);
    #1;

    // single reader, 18 words, back-to-back accept and return
    fork
      fetch(0, 18, 0);
      begin
        @(negedge clk);
        check("grant_lat0", 32'(grant), 0);
        @(negedge clk);
        check("grant_lat1", 32'(grant), 1);
      end
    join
    wait_drain();
    check("t1_ret0", 32'(ret_cnt[0]), 18);
    check("t1_ret1", 32'(ret_cnt[1] + ret_cnt[2]), 0);
    check("t1_idle_grant", 32'(grant), 0);
    check("t1_idle_read", 32'(avm_m0_read), 0);

    // three simultaneous requesters from reset, random controller stalls
    do_reset(1'b1);
    mem_rand = 1'b1;
    fork
      fetch(0, 4, 0);
      fetch(1, 4, 0);
      fetch(2, 4, 0);
    join
    fetch(0, 2, 0);
    wait_drain();
    mem_rand = 1'b0;
    check("rr_count", 32'(glog.size()), 4);
    check("rr_0", 32'(glog.size() > 0 ? glog[0] : '0), 1);
    check("rr_1", 32'(glog.size() > 1 ? glog[1] : '0), 2);
    check("rr_2", 32'(glog.size() > 2 ? glog[2] : '0), 4);
    check("rr_3", 32'(glog.size() > 3 ? glog[3] : '0), 1);
    check("rr_ret", 32'(ret_cnt[0] * 100 + ret_cnt[1] * 10 + ret_cnt[2]), 644);

    // owner pauses one cycle mid-element while port 1 waits
    glog.delete();
    fork
      fetch(0, 8, 4);
      begin
        repeat (3) @(posedge clk);
        #1;
        fetch(1, 2, 0);
      end
    join
    wait_drain();
    check("gap_count", 32'(glog.size()), 2);
    check("gap_0", 32'(glog.size() > 0 ? glog[0] : '0), 1);
    check("gap_1", 32'(glog.size() > 1 ? glog[1] : '0), 2);

    // slow controller: 19th read held at MAX_OUT outstanding
    do_reset(1'b1);
    mem_stall = 1'b1;
    fork
      fetch(0, 19, 0);
      begin
        int t = 0;
        while (sb.size() < MAXO && t < 500) begin
          @(posedge clk);
          #1;
          t++;
        end
        check("bp_accepted", 32'(sb.size()), MAXO);
        repeat (3) begin
          @(negedge clk);
          check("bp_read_held", 32'(avm_m0_read), 0);
          check("bp_owner_wait", 32'(rq_waitrequest[0]), 1);
        end
        @(posedge clk);
        #1;
        mem_stall = 1'b0;
      end
    join
    wait_drain();
    check("bp_ret", 32'(ret_cnt[0]), 19);
    check("bp_idle", 32'(grant), 0);

    // reset with 5 outstanding; late returns must be dropped and flagged
    do_reset(1'b1);
    mem_stall = 1'b1;
    fetch(0, 5, 0);
    check("orph_accepted", 32'(sb.size()), 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("orph_rst_grant", 32'(grant), 0);
    check("orph_rst_flag", 32'(err_orphan), 0);
    @(posedge clk);
    #1;
    mem_stall = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("orph_flag", 32'(err_orphan), 1);
    check("orph_grant", 32'(grant), 0);
    check("orph_returned", 32'(mem_q.size()), 0);
    do_reset(1'b1);
    @(negedge clk);
    check("orph_cleared", 32'(err_orphan), 0);

    check("nonowner_wait", 32'(bad_wait), 0);
    check("interleave", 32'(bad_mix), 0);
    check("stray_rdv", 32'(stray), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
